// File: rtl/phy_tx_partoserial.sv
// phy_tx_partoserial: transmit-side parallel-to-serial converter.
// After reset it sends SYNC_COUNT COM symbols so the receiver can lock.
// It then sends one symbol every 8 clk_8f cycles, MSB first.
// Each symbol is the held data word, or IDL when no word is waiting.
module phy_tx_partoserial #(
    parameter int unsigned SYNC_COUNT = 4,
    parameter logic [7:0]  COM        = 8'hBC,
    parameter logic [7:0]  IDL        = 8'h7C
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       symbol_start,
    output logic       active
);

    localparam logic [7:0] SYNC_LIMIT = 8'(SYNC_COUNT);

    logic [7:0] shift_q,     shift_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] sync_cnt_q,  sync_cnt_d;
    logic [7:0] hold_q,      hold_d;
    logic       hold_full_q, hold_full_d;
    logic       active_q,    active_d;

    logic       boundary;
    logic       in_sync;
    logic       capture;

    // The bit counter starts at 7 after reset, so the first edge is a symbol boundary.
    assign boundary = (bit_cnt_q == 3'd7);
    assign in_sync  = (sync_cnt_q < SYNC_LIMIT);
    // Capture needs an empty holding register, so it never coincides with an unload.
    assign capture  = valid_in && !hold_full_q;

    // Next-state logic: the symbol loader at boundaries and the MSB-first shifter between them.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        sync_cnt_d  = sync_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        active_d    = active_q;

        if (capture) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        if (boundary) begin
            bit_cnt_d = 3'd0;
            if (in_sync) begin
                // A word captured during sync waits in hold until the burst is done.
                shift_d    = COM;
                sync_cnt_d = sync_cnt_q + 8'd1;
            end else if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                active_d    = 1'b1;
            end else begin
                shift_d  = IDL;
                active_d = 1'b1;
            end
        end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    // State registers; an asynchronous reset drops any partial symbol and any held word.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd7;
            sync_cnt_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            active_q    <= active_d;
        end
    end

    assign data_out     = shift_q[7];
    assign symbol_start = (bit_cnt_q == 3'd0);
    assign ready_out    = !hold_full_q;
    assign active       = active_q;

endmodule

// File: tb/tb_phy_tx_partoserial.sv
// Bench for phy_tx_partoserial: expected serial bits are queued per test and
// compared as the DUT shifts them out. A second instance uses SYNC_COUNT = 1.
module tb_phy_tx_partoserial;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    logic       clk_8f = 1'b0;
    logic       reset_L  = 1'b0;
    logic       reset1_L = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic [7:0] data1_in = 8'h00;
    logic       valid_in  = 1'b0;
    logic       valid1_in = 1'b0;
    logic       ready_out, data_out, symbol_start, active;
    logic       ready1_out, data1_out, sym1_start, active1;

    phy_tx_partoserial #(.SYNC_COUNT(4), .COM(COM), .IDL(IDL)) dut (
        .clk_8f      (clk_8f),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .symbol_start(symbol_start),
        .active      (active)
    );

    phy_tx_partoserial #(.SYNC_COUNT(1), .COM(COM), .IDL(IDL)) dut1 (
        .clk_8f      (clk_8f),
        .reset_L     (reset1_L),
        .data_in     (data1_in),
        .valid_in    (valid1_in),
        .ready_out   (ready1_out),
        .data_out    (data1_out),
        .symbol_start(sym1_start),
        .active      (active1)
    );

    always #5 clk_8f = ~clk_8f;

    int checks = 0;
    int errors = 0;
    int cyc  = 0;
    int cyc1 = 0;
    bit chk_main = 1'b0;
    bit exp_q[$];
    bit exp1_q[$];
    bit src_en = 1'b0;
    logic [7:0] src_q[$];

    typedef struct {
        logic [7:0] word;
        int         offer;
        int         bnd;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_sym(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) exp_q.push_back(s[i]);
    endtask

    task automatic push1_sym(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) exp1_q.push_back(s[i]);
    endtask

    // One clock: sample #1 after the rising edge, then advance the source.
    task automatic step();
        logic rdy_pre;
        rdy_pre = ready_out;
        @(posedge clk_8f);
        #1;
        cyc++;
        cyc1++;
        if (exp_q.size() > 0) begin
            check("data_out", 8'(data_out), 8'(exp_q.pop_front()));
            if (chk_main) begin
                check("symbol_start", 8'(symbol_start), 8'((cyc % 8) == 1));
                check("active", 8'(active), 8'(cyc >= 33));
            end
        end
        if (exp1_q.size() > 0) begin
            check("s1_data_out", 8'(data1_out), 8'(exp1_q.pop_front()));
            check("s1_symbol_start", 8'(sym1_start), 8'((cyc1 % 8) == 1));
            check("s1_active", 8'(active1), 8'(cyc1 >= 9));
        end
        if (src_en) begin
            if (valid_in && rdy_pre && src_q.size() > 0) void'(src_q.pop_front());
            valid_in = (src_q.size() > 0);
            data_in  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    endtask

    // Holds reset for two edges, checks reset outputs, releases just after an edge.
    task automatic do_reset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        src_en   = 1'b0;
        src_q.delete();
        exp_q.delete();
        @(posedge clk_8f); #1;
        @(posedge clk_8f); #1;
        check("rst_data_out", 8'(data_out), 8'h00);
        check("rst_symbol_start", 8'(symbol_start), 8'h00);
        check("rst_ready", 8'(ready_out), 8'h01);
        check("rst_active", 8'(active), 8'h00);
        reset_L = 1'b1;
        cyc = 0;
    endtask

    initial begin
        tbl[0] = '{word: 8'hA5, offer: 39, bnd: 41};
        tbl[1] = '{word: 8'hC3, offer: 33, bnd: 41};
        tbl[2] = '{word: 8'h0F, offer: 40, bnd: 49};
        tbl[3] = '{word: 8'hBC, offer: 47, bnd: 49};
        tbl[4] = '{word: 8'h7C, offer: 55, bnd: 57};

        // Idle link: sync burst then IDL.
        chk_main = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) push_sym(COM);
        push_sym(IDL);
        push_sym(IDL);
        repeat (48) begin
            step();
            check("idle_ready", 8'(ready_out), 8'h01);
        end

        // Single words at various offsets relative to the symbol boundary.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int k = 0; k < 4; k++) push_sym(COM);
            for (int s = 33; s < tbl[i].bnd; s += 8) push_sym(IDL);
            push_sym(tbl[i].word);
            push_sym(IDL);
            while (cyc < tbl[i].offer) step();
            valid_in = 1'b1;
            data_in  = tbl[i].word;
            step();
            valid_in = 1'b0;
            data_in  = 8'h00;
            check("ready_after_capture", 8'(ready_out), 8'h00);
            while (cyc < tbl[i].bnd) step();
            check("ready_after_unload", 8'(ready_out), 8'h01);
            while (exp_q.size() > 0) step();
        end

        // Back-to-back words at full rate, no IDL gaps.
        do_reset();
        for (int k = 0; k < 4; k++) push_sym(COM);
        push_sym(IDL);
        push_sym(8'h01);
        push_sym(8'h02);
        push_sym(8'h03);
        push_sym(IDL);
        repeat (33) step();
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        src_q.push_back(8'h03);
        src_en   = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'h01;
        while (exp_q.size() > 0) step();
        check("b2b_all_accepted", 8'(src_q.size()), 8'h00);
        src_en   = 1'b0;
        valid_in = 1'b0;

        // Word captured during sync; a second offer while full is ignored.
        do_reset();
        for (int k = 0; k < 4; k++) push_sym(COM);
        push_sym(8'h3C);
        push_sym(IDL);
        push_sym(IDL);
        repeat (4) step();
        valid_in = 1'b1;
        data_in  = 8'h3C;
        step();
        valid_in = 1'b0;
        check("sync_capture_ready", 8'(ready_out), 8'h00);
        repeat (4) step();
        valid_in = 1'b1;
        data_in  = 8'h55;
        step();
        valid_in = 1'b0;
        data_in  = 8'h00;
        while (cyc < 32) begin
            step();
            check("sync_hold_ready", 8'(ready_out), 8'h00);
        end
        step();
        check("sync_unload_ready", 8'(ready_out), 8'h01);
        while (exp_q.size() > 0) step();

        // Asynchronous reset mid-symbol with a word held.
        do_reset();
        for (int k = 0; k < 4; k++) push_sym(COM);
        push_sym(IDL);
        push_sym(8'hFF);
        repeat (33) step();
        valid_in = 1'b1;
        data_in  = 8'hFF;
        step();
        valid_in = 1'b0;
        while (cyc < 41) step();
        valid_in = 1'b1;
        data_in  = 8'h77;
        step();
        valid_in = 1'b0;
        data_in  = 8'h00;
        check("held_word_ready", 8'(ready_out), 8'h00);
        while (cyc < 45) step();
        exp_q.delete();
        #2;
        reset_L = 1'b0;
        #1;
        check("async_data_out", 8'(data_out), 8'h00);
        check("async_active", 8'(active), 8'h00);
        check("async_ready", 8'(ready_out), 8'h01);
        check("async_symbol_start", 8'(symbol_start), 8'h00);
        @(posedge clk_8f); #1;
        reset_L = 1'b1;
        cyc = 0;
        for (int k = 0; k < 4; k++) push_sym(COM);
        push_sym(IDL);
        push_sym(IDL);
        push_sym(IDL);
        while (exp_q.size() > 0) begin
            step();
            check("post_reset_ready", 8'(ready_out), 8'h01);
        end

        // SYNC_COUNT = 1 instance: one COM, then data.
        chk_main = 1'b0;
        @(posedge clk_8f); #1;
        reset1_L = 1'b1;
        cyc1 = 0;
        push1_sym(COM);
        push1_sym(8'h5A);
        push1_sym(IDL);
        step();
        step();
        valid1_in = 1'b1;
        data1_in  = 8'h5A;
        step();
        valid1_in = 1'b0;
        data1_in  = 8'h00;
        check("s1_ready_after_capture", 8'(ready1_out), 8'h00);
        while (cyc1 < 9) step();
        check("s1_ready_after_unload", 8'(ready1_out), 8'h01);
        while (exp1_q.size() > 0) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phy_tx_partoserial.md
# phy_tx_partoserial

Transmit half of the PCIe-style phy: accepts 8-bit parallel words through a valid/ready handshake and shifts them out MSB-first on a single serial line, one bit per `clk_8f` cycle. After reset it emits a burst of COM symbols so the receive-side serial-to-parallel block can lock. Once locked it sends either accepted data or IDL filler on every symbol slot. It sits between the phy's parallel byte source and the serial link that feeds the receiver.

## Interface
Parameters:
- `SYNC_COUNT`, 4: number of COM symbols sent after reset before data is allowed out; legal range 1..255.
- `COM`, 8'hBC: sync/comma symbol.
- `IDL`, 8'h7C: idle filler symbol.

Ports:
- `clk_8f` input 1: bit-rate clock; the only clock in the block, all logic on its rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `data_in` input 8: parallel word to transmit.
- `valid_in` input 1: `data_in` is valid this cycle.
- `ready_out` output 1: the holding register can accept a word this cycle.
- `data_out` output 1: serial bit, MSB of each symbol first.
- `symbol_start` output 1: high while `data_out` carries bit 7 of a symbol.
- `active` output 1: sync burst complete; the link is carrying data/IDL.

## Operation
- Registers:
  - `shift[7:0]`
  - `bit_cnt[2:0]`
  - `sync_cnt[7:0]`
  - `hold[7:0]`
  - `hold_full`
  - `active`
- `data_out = shift[7]`. `symbol_start = (bit_cnt == 0)`. `ready_out = ~hold_full`. All three are combinational from registers.
- Reset (async, `reset_L` = 0) forces:
  - `shift` = 0, `bit_cnt` = 7, `sync_cnt` = 0, `hold` = 0, `hold_full` = 0, `active` = 0.
  - Resulting outputs: `data_out` = 0, `symbol_start` = 0, `ready_out` = 1, `active` = 0.
- Capture: on a rising edge with `valid_in & ready_out`, `hold` ← `data_in` and `hold_full` ← 1. Words offered while `ready_out` = 0 are ignored; the source must hold them.
- Symbol boundary: a rising edge with `bit_cnt == 7`. At the boundary `bit_cnt` ← 0, and `shift` is loaded by priority:
  1. SYNC (`sync_cnt < SYNC_COUNT`): load `COM`; `sync_cnt` += 1.
  2. ACTIVE with `hold_full` = 1: load `hold`; `hold_full` ← 0; `active` ← 1.
  3. ACTIVE with `hold_full` = 0: load `IDL`; `active` ← 1.
- Non-boundary edge: `shift` ← {shift[6:0], 1'b0}; `bit_cnt` += 1.
- `sync_cnt` saturates at `SYNC_COUNT`. `active` stays 1 until reset.
- Words may be captured during SYNC. They wait in `hold` (`ready_out` = 0) until the first post-sync boundary.
- Capture and unload never coincide, because capture requires `hold_full` = 0.
- Data bytes equal to `COM` or `IDL` are sent verbatim. Keeping such values out of the payload is the source's responsibility.

## Timing
- Edge 1 after reset release is a boundary and loads `COM`. The first `COM` bit is visible from edge 1.
- Each symbol occupies exactly 8 cycles. Boundaries fall on edges 1, 9, 17, … (8k+1).
- SYNC symbols load on edges 1 … 8·(SYNC_COUNT−1)+1. `active` rises on edge 8·SYNC_COUNT+1, which is edge 33 for the default.
- Latency, hold empty and link active: a word captured on edge t appears at the next boundary b > t. Its MSB is on `data_out` from edge b, its LSB from edge b+7.
- `ready_out` re-asserts the cycle after unload, i.e. from edge b. A source that presents a new word within 7 cycles sustains full rate: 1 byte per 8 cycles, no IDL gaps.
- Reset asserted mid-symbol: outputs take their reset values immediately, without waiting for a clock. The partial symbol and any held word are discarded. Sync restarts from `sync_cnt` = 0 after release.

## Test plan
- Reset, `valid_in` = 0 for 48 cycles:
  - `data_out` = 10111100 repeated 4 times on cycles 1–32, then 01111100 on cycles 33–40 and 41–48.
  - `symbol_start` high on cycles 1, 9, 17, …
  - `active` rises at edge 33.
- Single word 8'hA5 captured on edge 40: `data_out` = 10100101 on cycles 41–48, then IDL. `ready_out` is 0 on cycles 41–48 only if re-filled, otherwise 1 from edge 41.
- Back-to-back 8'h01, 8'h02, 8'h03, with `valid_in` held and each word presented as soon as `ready_out` = 1: three consecutive symbols 00000001, 00000010, 00000011 with no IDL between them.
- Word 8'h3C offered on cycle 5, during SYNC:
  - Captured on edge 5; `ready_out` = 0 until edge 33.
  - 8'h3C is sent on cycles 33–40; the 4 COMs are intact.
  - A second word offered on cycle 10 is not captured.
- `reset_L` dropped mid-symbol while sending 8'hFF at bit 3, plus a word held:
  - `data_out`, `active` and `ready_out` go to 0/0/1 asynchronously.
  - After release, a full 4-COM sync repeats and the held word is never sent.
- `SYNC_COUNT` = 1: a single COM on cycles 1–8; `active` rises at edge 9; data or IDL follows.
